// File: rtl/bin_morph_pkg.sv
// rtl/bin_morph_pkg.sv - mode codes, FSM state type and counter width helper for bin_morph_3x3
package bin_morph_pkg;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_ERODE  = 2'd1;
  localparam logic [1:0] MODE_DILATE = 2'd2;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bin_morph_3x3_if.sv
// rtl/bin_morph_3x3_if.sv - window input and filtered pixel output bundle of bin_morph_3x3
interface bin_morph_3x3_if;

  logic matrix_wr_en;
  logic matrix_p11, matrix_p12, matrix_p13;
  logic matrix_p21, matrix_p22, matrix_p23;
  logic matrix_p31, matrix_p32, matrix_p33;
  logic out_en;
  logic out_bit;
  logic out_sol;
  logic out_eof;

  modport master (
    output matrix_wr_en,
    output matrix_p11, matrix_p12, matrix_p13,
    output matrix_p21, matrix_p22, matrix_p23,
    output matrix_p31, matrix_p32, matrix_p33,
    input  out_en, out_bit, out_sol, out_eof
  );

  modport slave (
    input  matrix_wr_en,
    input  matrix_p11, matrix_p12, matrix_p13,
    input  matrix_p21, matrix_p22, matrix_p23,
    input  matrix_p31, matrix_p32, matrix_p33,
    output out_en, out_bit, out_sol, out_eof
  );

endinterface

// File: rtl/bin_morph_pos_cnt.sv
// rtl/bin_morph_pos_cnt.sv - raster x/y position counters; outputs give the position of the current beat
module bin_morph_pos_cnt
  import bin_morph_pkg::*;
#(
  parameter int IMG_W = 1600,
  parameter int IMG_H = 900,
  parameter int XW    = cnt_width(IMG_W),
  parameter int YW    = cnt_width(IMG_H)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          clear,
  input  logic          step,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          first,
  output logic          last_x,
  output logic          last_pix
);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  // clear is seen combinationally so a beat coincident with it is pixel (0,0)
  assign x        = clear ? '0 : x_q;
  assign y        = clear ? '0 : y_q;
  assign first    = (x == '0);
  assign last_x   = (x == XW'(IMG_W - 1));
  assign last_pix = last_x && (y == YW'(IMG_H - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (step) begin
      if (last_x) begin
        x_q <= '0;
        y_q <= last_pix ? '0 : y + 1'b1;
      end else begin
        x_q <= x + 1'b1;
        y_q <= y;
      end
    end else if (clear) begin
      x_q <= '0;
      y_q <= '0;
    end
  end

endmodule

// File: rtl/bin_morph_3x3.sv
// rtl/bin_morph_3x3.sv - 3x3 binary erode/dilate/pass filter with raster framing; BIN_MORPH_BORDER_MASK_EN zeroes morph borders
module bin_morph_3x3
  import bin_morph_pkg::*;
#(
  parameter int IMG_W = 1600,
  parameter int IMG_H = 900
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  frame_start,
  input  logic [1:0]            mode,
  bin_morph_3x3_if.slave        win,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int XW = cnt_width(IMG_W);
  localparam int YW = cnt_width(IMG_H);

`ifdef BIN_MORPH_BORDER_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_eff;
  logic          accept;
  logic [8:0]    window;
  logic          morph_bit;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          pix_first, pix_last_x, pix_last;

  logic          s1_valid, s1_bit, s1_first, s1_last, s1_last_x, s1_morph;
  logic [XW-1:0] s1_x;
  logic [YW-1:0] s1_y;
  logic          border;

  // a beat coincident with frame_start belongs to the new frame and its mode
  assign accept   = win.matrix_wr_en && (frame_start || state_q == ACTIVE);
  assign mode_eff = frame_start ? mode : mode_q;
  assign window   = {win.matrix_p11, win.matrix_p12, win.matrix_p13,
                     win.matrix_p21, win.matrix_p22, win.matrix_p23,
                     win.matrix_p31, win.matrix_p32, win.matrix_p33};

  bin_morph_pos_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .XW    (XW),
    .YW    (YW)
  ) u_pos_cnt (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .clear    (frame_start),
    .step     (accept),
    .x        (pix_x),
    .y        (pix_y),
    .first    (pix_first),
    .last_x   (pix_last_x),
    .last_pix (pix_last)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= WAIT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT:    if (frame_start) state_d = ACTIVE;
      ACTIVE:  if (frame_start) state_d = ACTIVE;
               else if (accept && pix_last) state_d = DONE;
      DONE:    if (frame_start) state_d = ACTIVE;
               else if (frame_done) state_d = WAIT;
      default: state_d = WAIT;
    endcase
  end

  always_comb begin
    busy = (state_q == ACTIVE);
  end

  always_comb begin
    case (mode_eff)
      MODE_PASS:   morph_bit = window[4];
      MODE_ERODE:  morph_bit = &window;
      MODE_DILATE: morph_bit = |window;
      default:     morph_bit = window[4];
    endcase
  end

  assign border = (s1_x == '0) || s1_last_x || (s1_y == '0) || (s1_y == YW'(IMG_H - 1));

  // frame_done follows out_eof so it trails the last emitted pixel, not the last accepted beat
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mode_q      <= MODE_PASS;
      s1_valid    <= 1'b0;
      s1_bit      <= 1'b0;
      s1_first    <= 1'b0;
      s1_last     <= 1'b0;
      s1_last_x   <= 1'b0;
      s1_morph    <= 1'b0;
      s1_x        <= '0;
      s1_y        <= '0;
      win.out_en  <= 1'b0;
      win.out_bit <= 1'b0;
      win.out_sol <= 1'b0;
      win.out_eof <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      if (frame_start) mode_q <= mode;
      s1_valid    <= accept;
      s1_bit      <= morph_bit;
      s1_first    <= pix_first;
      s1_last     <= pix_last;
      s1_last_x   <= pix_last_x;
      s1_morph    <= (mode_eff == MODE_ERODE) || (mode_eff == MODE_DILATE);
      s1_x        <= pix_x;
      s1_y        <= pix_y;
      win.out_en  <= s1_valid;
      win.out_bit <= s1_valid && s1_bit && !(MASK_EN && s1_morph && border);
      win.out_sol <= s1_valid && s1_first;
      win.out_eof <= s1_valid && s1_last;
      frame_done  <= win.out_eof;
    end
  end

endmodule
